// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IF stage of the RV32IM pipeline.
//
// Owns the fetch PC, issues word fetches to instruction memory (tolerating
// multi-cycle busywait) and presents {PC, PC+4, instruction, valid} to IF/ID.
// A one-entry skid buffer absorbs a word that completes while ID is holding,
// and a discard state drops a fetch that was in flight when EX redirected.
//
// Optional build macro: IFU_PERF_CNT_EN adds FETCH_COUNT / WAIT_COUNT.
//
// Ports:
//   CLK            clock, rising edge
//   RESET          asynchronous active-low reset
//   HOLD           ID not accepting; IF_* outputs held
//   BRANCH_TAKEN   one-cycle redirect pulse from EX
//   BRANCH_TARGET  redirect address (bits [1:0] ignored)
//   IMEM_ADDR      fetch address (always the fetch PC)
//   IMEM_READ      fetch request
//   IMEM_READDATA  instruction word, valid on completion
//   IMEM_BUSYWAIT  memory not ready
//   IF_PC/IF_PC4   PC of presented instruction and PC+4
//   IF_INST        presented instruction (NOP on bubble)
//   IF_VALID       presented instruction is real
//   FETCH_COUNT    (IFU_PERF_CNT_EN) delivered completions
//   WAIT_COUNT     (IFU_PERF_CNT_EN) cycles stalled on busywait
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HOLD,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  output logic [31:0] IF_INST,
  output logic        IF_VALID
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] WAIT_COUNT
`endif
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StFetch, StFull, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;

  logic        completion;
  logic        deliver;
  logic        skid_fill;
  logic [31:0] target;
  logic        unused_tgt_lsb;

  assign target         = {BRANCH_TARGET[31:2], 2'b00};
  assign unused_tgt_lsb = ^BRANCH_TARGET[1:0];

  // Request is masked combinationally so it drops the moment reset asserts.
  assign IMEM_READ  = RESET & (state_q != StFull);
  assign IMEM_ADDR  = pc_q;
  assign completion = IMEM_READ & ~IMEM_BUSYWAIT;
  // A completing word is kept only in StFetch and only without a redirect.
  assign deliver    = completion & (state_q == StFetch) & ~BRANCH_TAKEN;
  assign skid_fill  = deliver & (HOLD | skid_valid_q);

  assign IF_PC    = if_pc_q;
  assign IF_PC4   = if_pc_q + 32'd4;
  assign IF_INST  = if_inst_q;
  assign IF_VALID = if_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    if_valid_d   = if_valid_q;

    if (BRANCH_TAKEN) begin
      if_valid_d   = 1'b0;
      if_inst_d    = Nop;
      skid_valid_d = 1'b0;
      if (IMEM_READ && IMEM_BUSYWAIT) begin
        // Cannot abandon the in-flight access; drain it first.
        pending_d = target;
        state_d   = StDiscard;
      end else begin
        pc_d    = target;
        state_d = StFetch;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (completion) begin
            pc_d = pc_q + 32'd4;
            if (skid_fill) state_d = StFull;
          end
        end
        StFull: begin
          if (!HOLD) state_d = StFetch;
        end
        StDiscard: begin
          if (completion) begin
            pc_d    = pending_q;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase

      if (!HOLD) begin
        if (skid_valid_q) begin
          if_pc_d    = skid_pc_q;
          if_inst_d  = skid_inst_q;
          if_valid_d = 1'b1;
        end else if (deliver) begin
          if_pc_d    = pc_q;
          if_inst_d  = IMEM_READDATA;
          if_valid_d = 1'b1;
        end else begin
          if_inst_d  = Nop;
          if_valid_d = 1'b0;
        end
      end

      if (skid_fill) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = IMEM_READDATA;
        skid_pc_d    = pc_q;
      end else if (!HOLD) begin
        skid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StFetch;
      pc_q         <= RESET_VECTOR;
      pending_q    <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= Nop;
      skid_pc_q    <= 32'h0;
      if_pc_q      <= 32'h0;
      if_inst_q    <= Nop;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      if_valid_q   <= if_valid_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q, wait_count_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_count_q <= 32'h0;
      wait_count_q  <= 32'h0;
    end else begin
      if (deliver) fetch_count_q <= fetch_count_q + 32'd1;
      if (IMEM_READ && IMEM_BUSYWAIT) wait_count_q <= wait_count_q + 32'd1;
    end
  end

  assign FETCH_COUNT = fetch_count_q;
  assign WAIT_COUNT  = wait_count_q;
`endif

endmodule
